vga_timing_gen: RTL

//  Parametrised VGA/VESA raster timing generator; next generation of the fixed 800x600@60 sync block.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing presets and helpers for the VGA raster generator family.
package vga_timing_pkg;

  typedef struct packed {
    logic [31:0] act;
    logic [31:0] fp;
    logic [31:0] sync;
    logic [31:0] bp;
  } axis_timing_t;

  // Presets are listed as {active, front porch, sync, back porch}.
  localparam axis_timing_t VGA_640X480_H  = '{32'd640,  32'd16, 32'd96,  32'd48};
  localparam axis_timing_t VGA_640X480_V  = '{32'd480,  32'd10, 32'd2,   32'd33};
  localparam axis_timing_t VGA_800X600_H  = '{32'd800,  32'd40, 32'd128, 32'd88};
  localparam axis_timing_t VGA_800X600_V  = '{32'd600,  32'd1,  32'd4,   32'd23};
  localparam axis_timing_t VGA_1024X768_H = '{32'd1024, 32'd24, 32'd136, 32'd160};
  localparam axis_timing_t VGA_1024X768_V = '{32'd768,  32'd3,  32'd6,   32'd29};

  localparam int unsigned FRAME_CNT_W = 32'd16;

  function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with active-area and sync-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW   = 32'd11,
  parameter int unsigned ACT  = 32'd800,
  parameter int unsigned FP   = 32'd40,
  parameter int unsigned SYNC = 32'd128,
  parameter int unsigned BP   = 32'd88,
  parameter logic        POL  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync_lvl
);

  localparam int unsigned   TOTAL    = timing_total(ACT, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 32'd1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACT);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACT + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACT + FP + SYNC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap     = step && (cnt_q == LAST);
  assign cnt_d    = wrap ? '0 : cnt_q + CW'(1);
  assign cnt      = cnt_q;
  assign active   = (cnt_q < ACT_END);
  assign sync_lvl = ((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END)) ? POL : ~POL;

  // Position counter, advancing only on qualified steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a pixel-request port PIX_LAT clocks ahead.
// Optional 16-bit frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW      = 32'd11,
  parameter int unsigned H_ACT   = VGA_800X600_H.act,
  parameter int unsigned H_FP    = VGA_800X600_H.fp,
  parameter int unsigned H_SYNC  = VGA_800X600_H.sync,
  parameter int unsigned H_BP    = VGA_800X600_H.bp,
  parameter int unsigned V_ACT   = VGA_800X600_V.act,
  parameter int unsigned V_FP    = VGA_800X600_V.fp,
  parameter int unsigned V_SYNC  = VGA_800X600_V.sync,
  parameter int unsigned V_BP    = VGA_800X600_V.bp,
  parameter logic        H_POL   = 1'b1,
  parameter logic        V_POL   = 1'b1,
  parameter int unsigned PIX_LAT = 32'd2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam longint unsigned CNT_RANGE = 64'd1 << CW;
  localparam int unsigned H_TOTAL = timing_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACT, V_FP, V_SYNC, V_BP);

  if ((H_ACT < 32'd1) || (H_FP < 32'd1) || (H_SYNC < 32'd1) || (H_BP < 32'd1) ||
      (V_ACT < 32'd1) || (V_FP < 32'd1) || (V_SYNC < 32'd1) || (V_BP < 32'd1) ||
      (64'(H_TOTAL) > CNT_RANGE) || (64'(V_TOTAL) > CNT_RANGE) || (PIX_LAT > 32'd15))
  begin : g_bad_cfg
    $fatal(1, "vga_timing_gen: illegal timing parameters");
  end

  // Stage word layout, LSB first: fs, ls, vs, hs, req_y, req_x, req [, frame count].
  localparam int unsigned RY_LSB = 32'd4;
  localparam int unsigned RX_LSB = RY_LSB + CW;
  localparam int unsigned RQ_BIT = RX_LSB + CW;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int unsigned FC_LSB = RQ_BIT + 32'd1;
  localparam int unsigned SW     = FC_LSB + FRAME_CNT_W;
`else
  localparam int unsigned SW     = RQ_BIT + 32'd1;
`endif
  localparam logic [SW-1:0] RST_VAL = SW'({~H_POL, ~V_POL, 2'b00});

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap, h_act, v_act, h_lvl, v_lvl;
  logic          req_s;
  logic [SW-1:0] st0_d;
  logic [SW-1:0] pipe_q [0:PIX_LAT];
  logic [SW-1:0] disp_s;

  vga_axis_counter #(
    .CW(CW), .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(pix_en),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync_lvl(h_lvl)
  );

  vga_axis_counter #(
    .CW(CW), .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync_lvl(v_lvl)
  );

  assign req_s = h_act && v_act;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] fcnt_q;
  logic [FRAME_CNT_W-1:0] fcnt_d;

  assign fcnt_d = fcnt_q + 16'd1;

  // Completed-frame counter; stage 0 samples it when (0,0) is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else if (v_wrap) begin
      fcnt_q <= fcnt_d;
    end
  end

  assign st0_d = {fcnt_q, req_s, req_s ? h_cnt : '0, req_s ? v_cnt : '0,
                  h_lvl, v_lvl, (h_cnt == '0), (h_cnt == '0) && (v_cnt == '0)};
  assign frame_cnt = disp_s[FC_LSB +: FRAME_CNT_W];
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
  assign st0_d = {req_s, req_s ? h_cnt : '0, req_s ? v_cnt : '0,
                  h_lvl, v_lvl, (h_cnt == '0), (h_cnt == '0) && (v_cnt == '0)};
`endif

  // Stage 0: decode of the current raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q[0] <= RST_VAL;
    end else if (pix_en) begin
      pipe_q[0] <= st0_d;
    end
  end

  for (genvar i = 1; i <= PIX_LAT; i++) begin : g_dly
    // Delay stage matching the pixel source latency.
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_q[i] <= RST_VAL;
      end else if (pix_en) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign disp_s = pipe_q[PIX_LAT];

  assign req         = pipe_q[0][RQ_BIT];
  assign req_x       = pipe_q[0][RX_LSB +: CW];
  assign req_y       = pipe_q[0][RY_LSB +: CW];
  assign de          = disp_s[RQ_BIT];
  assign x           = disp_s[RX_LSB +: CW];
  assign y           = disp_s[RY_LSB +: CW];
  assign hsync       = disp_s[3];
  assign vsync       = disp_s[2];
  assign line_start  = disp_s[1];
  assign frame_start = disp_s[0];

endmodule
